ysyx_22041211_mem_arbiter: RTL

- Shares one data-memory port between the instruction-fetch unit (read-only) and the load/store path (read/write).
- Accepts one request at a time, sequences it onto a valid/ready memory request channel, waits for the memory response and routes the registered result back to the owner.
- LSU has priority, with a starvation guard for IFU.
- Adds a response timeout and an LSU alignment/mask check, so a stuck or illegal access returns an error instead of hanging the pipeline.

---
 rtl/ysyx_22041211_mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Data-memory arbiter: one valid/ready memory port shared by IFU (read) and LSU (read/write).
// LSU has priority with an IFU starvation guard; LSU alignment check and response timeout.
module ysyx_22041211_mem_arbiter #(
    parameter int DATA_LEN       = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [DATA_LEN-1:0] ifu_raddr,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_mask,
    output logic                lsu_rsp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [7:0]          mem_mask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam logic [3:0] SLIMIT  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                owner;
    logic [DATA_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                wen_q;
    logic                err_q;
    logic [7:0]          mask_q;
    logic [3:0]          starve_cnt;
    logic [7:0]          tmo_cnt;

    logic lsu_win;
    logic ifu_win;
    logic lsu_acc;
    logic ifu_acc;
    logic accept;
    logic lsu_illegal;
    logic busy;
    logic tmo_hit;

    always_comb begin
        lsu_win = lsu_req_valid && (starve_cnt != SLIMIT);
        ifu_win = !lsu_win && ifu_req_valid;
        lsu_acc = (state == IDLE) && lsu_win;
        ifu_acc = (state == IDLE) && ifu_win;
        accept  = lsu_acc || ifu_acc;
        busy    = (state == REQ) || (state == WAIT);
        tmo_hit = busy && (tmo_cnt == TO_LAST);
    end

    always_comb begin
        case (lsu_mask)
            8'h01:   lsu_illegal = 1'b0;
            8'h03:   lsu_illegal = lsu_addr[0];
            8'h0F:   lsu_illegal = |lsu_addr[1:0];
            default: lsu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal LSU requests skip the memory and go straight to an error response.
    always_comb begin
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = ifu_win && !rst;
                lsu_req_ready = lsu_win && !rst;
                if (lsu_acc) begin
                    state_nxt = lsu_illegal ? RESP : REQ;
                end else if (ifu_acc) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = !tmo_hit;
                if (tmo_hit) begin
                    state_nxt = RESP;
                end else if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ifu_rsp_valid = !owner;
                lsu_rsp_valid = owner;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (accept) begin
                owner   <= lsu_acc;
                addr_q  <= lsu_acc ? lsu_addr : ifu_raddr;
                wen_q   <= lsu_acc && lsu_wen;
                wdata_q <= lsu_acc ? lsu_wdata : '0;
                mask_q  <= lsu_acc ? lsu_mask : 8'h0F;
                rdata_q <= '0;
                err_q   <= lsu_acc && lsu_illegal;
                tmo_cnt <= '0;
            end else if (busy) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            // A real response in the timeout cycle still counts as a success.
            if (state == WAIT && mem_rsp_valid) begin
                rdata_q <= wen_q ? '0 : mem_rdata;
                err_q   <= 1'b0;
            end else if (tmo_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (lsu_acc) begin
            if (!ifu_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (ifu_acc) begin
            starve_cnt <= '0;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wen     = wen_q;
    assign mem_wdata   = wdata_q;
    assign mem_mask    = mask_q;
    assign ifu_rdata   = ifu_rsp_valid ? rdata_q : '0;
    assign ifu_rsp_err = ifu_rsp_valid && err_q;
    assign lsu_rdata   = lsu_rsp_valid ? rdata_q : '0;
    assign lsu_rsp_err = lsu_rsp_valid && err_q;

endmodule
